// File: rtl/hazard_mc.sv
// Hazard controller for the 5-stage RV32 core: E-stage forwarding, load-use/RAW stalls,
// branch flushes, multi-cycle MUL/DIV hold of E, and a saturating stall-cycle counter.
module hazard_mc #(
    parameter int REG_AW  = 5,
    parameter int MUL_LAT = 3,
    parameter int FWD_EN  = 1,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              PCSrcE,
    input  logic              MemReadE,
    input  logic              MulE,
    input  logic              RegWriteE,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              StallCntClr,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushM,
    output logic              MulBusy,
    output logic [CNT_W-1:0]  StallCycles
);

    localparam int CW = ($clog2(MUL_LAT) > 0) ? $clog2(MUL_LAT) : 1;
    localparam logic [CW-1:0] CNT_INIT = (MUL_LAT > 1) ? CW'(MUL_LAT - 2) : '0;

    typedef enum logic {IDLE, BUSY} mcState_t;

    mcState_t          mcState;
    logic [CW-1:0]     mcCnt;
    logic              mcStall;
    logic              lwStall;
    logic              rawStall;
    logic              dStall;

    logic [REG_AW-1:0] rsE [2];
    logic [REG_AW-1:0] rsD [2];
    logic [1:0]        fwdSel [2];
    logic              lwHit [2];
    logic              rawHit [2];

    assign rsE[0] = Rs1E;
    assign rsE[1] = Rs2E;
    assign rsD[0] = Rs1D;
    assign rsD[1] = Rs2D;

    // Per-operand selects and hits; x0 is hardwired zero so it never forwards or hazards.
    for (genvar gi = 0; gi < 2; gi++) begin : g_operand
        assign fwdSel[gi] = (FWD_EN == 0 || rsE[gi] == '0)      ? 2'b00 :
                            (RegWriteM && rsE[gi] == RdM)        ? 2'b10 :
                            (RegWriteW && rsE[gi] == RdW)        ? 2'b01 : 2'b00;
        assign lwHit[gi]  = MemReadE && (RdE != '0) && (rsD[gi] == RdE);
        assign rawHit[gi] = (FWD_EN == 0) && (rsD[gi] != '0) &&
                            ((RegWriteE && rsD[gi] == RdE) || (RegWriteM && rsD[gi] == RdM));
    end

    assign lwStall  = lwHit[0] | lwHit[1];
    assign rawStall = rawHit[0] | rawHit[1];
    assign dStall   = lwStall | rawStall;

    // The op is held for MUL_LAT-1 stall cycles; the cycle leaving BUSY lets it go.
    assign mcStall = (mcState == IDLE) ? (MulE && (MUL_LAT > 1)) : (mcCnt != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcState <= IDLE;
            mcCnt   <= '0;
        end else begin
            case (mcState)
                IDLE: begin
                    if (MulE && (MUL_LAT > 1)) begin
                        mcState <= BUSY;
                        mcCnt   <= CNT_INIT;
                    end
                end
                BUSY: begin
                    if (mcCnt != '0) begin
                        mcCnt <= mcCnt - 1'b1;
                    end else begin
                        mcState <= IDLE;
                    end
                end
                default: mcState <= IDLE;
            endcase
        end
    end

    // mcStall dominates every flush so a held E is never bubbled.
    assign ForwardAE = reset ? 2'b00 : fwdSel[0];
    assign ForwardBE = reset ? 2'b00 : fwdSel[1];
    assign StallE    = ~reset & mcStall;
    assign StallF    = ~reset & (mcStall | dStall);
    assign StallD    = ~reset & (mcStall | dStall);
    assign FlushM    = reset | mcStall;
    assign FlushD    = reset | (PCSrcE & ~mcStall);
    assign FlushE    = reset | ((dStall | PCSrcE) & ~mcStall);
    assign MulBusy   = (mcState == BUSY);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            StallCycles <= '0;
        end else if (StallCntClr) begin
            StallCycles <= '0;
        end else if (StallF && !(&StallCycles)) begin
            StallCycles <= StallCycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_mc.sv
// Bench for hazard_mc: directed scenarios plus randomized traffic against a rule-level model,
// using a forwarding instance (MUL_LAT=3) and a no-forwarding instance (MUL_LAT=2, 4-bit counter).
module tb_hazard_mc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       PCSrcE, MemReadE, MulE, RegWriteE, RegWriteM, RegWriteW, StallCntClr;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;

    logic [1:0]  aFwdA, aFwdB, bFwdA, bFwdB;
    logic        aStallF, aStallD, aStallE, aFlushD, aFlushE, aFlushM, aBusy;
    logic        bStallF, bStallD, bStallE, bFlushD, bFlushE, bFlushM, bBusy;
    logic [15:0] aCnt;
    logic [3:0]  bCnt;

    int vectors = 0;
    int miscompares = 0;

    hazard_mc #(.REG_AW(5), .MUL_LAT(3), .FWD_EN(1), .CNT_W(16)) dutA (
        .clk(clk), .reset(reset), .PCSrcE(PCSrcE), .MemReadE(MemReadE), .MulE(MulE),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .StallCntClr(StallCntClr), .ForwardAE(aFwdA), .ForwardBE(aFwdB),
        .StallF(aStallF), .StallD(aStallD), .StallE(aStallE),
        .FlushD(aFlushD), .FlushE(aFlushE), .FlushM(aFlushM),
        .MulBusy(aBusy), .StallCycles(aCnt)
    );

    hazard_mc #(.REG_AW(5), .MUL_LAT(2), .FWD_EN(0), .CNT_W(4)) dutB (
        .clk(clk), .reset(reset), .PCSrcE(PCSrcE), .MemReadE(MemReadE), .MulE(MulE),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .StallCntClr(StallCntClr), .ForwardAE(bFwdA), .ForwardBE(bFwdB),
        .StallF(bStallF), .StallD(bStallD), .StallE(bStallE),
        .FlushD(bFlushD), .FlushE(bFlushE), .FlushM(bFlushM),
        .MulBusy(bBusy), .StallCycles(bCnt)
    );

    task automatic idleIn();
        PCSrcE = 0; MemReadE = 0; MulE = 0; RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
        StallCntClr = 0;
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    endtask

    task automatic toNext();
        @(posedge clk);
        #1;
    endtask

    // Reference rules for one instance; busyLeft = cycles the op still spends in BUSY.
    function automatic logic [1:0] fwdModel(int fwdEn, logic [4:0] rs);
        if (fwdEn == 0 || rs == 0) return 2'b00;
        if (RegWriteM && rs == RdM) return 2'b10;
        if (RegWriteW && rs == RdW) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic rawModel(logic [4:0] rs);
        return (rs != 0) && ((RegWriteE && rs == RdE) || (RegWriteM && rs == RdM));
    endfunction

    function automatic logic [10:0] model(int fwdEn, int mulLat, int busyLeft);
        logic lw, raw, mc, dS;
        lw  = MemReadE && RdE != 0 && (Rs1D == RdE || Rs2D == RdE);
        raw = (fwdEn == 0) && (rawModel(Rs1D) || rawModel(Rs2D));
        mc  = (busyLeft > 1) || (busyLeft == 0 && MulE && mulLat > 1);
        dS  = lw | raw;
        return {fwdModel(fwdEn, Rs1E), fwdModel(fwdEn, Rs2E), mc | dS, mc | dS, mc,
                PCSrcE & ~mc, (dS | PCSrcE) & ~mc, mc, 1'(busyLeft > 0)};
    endfunction

    task automatic test_reset();
        reset = 1; idleIn();
        RdM = 7; Rs1E = 7; RegWriteM = 1; MemReadE = 1; RdE = 5; Rs1D = 5; MulE = 1; PCSrcE = 1;
        @(negedge clk);
        vectors++;
        if ({aStallF, aStallD, aStallE, aFlushD, aFlushE, aFlushM, aFwdA, aFwdB, aBusy} !== 11'b00011100000) begin
            miscompares++;
            $display("FAIL reset_outputs got %b want 00011100000",
                     {aStallF, aStallD, aStallE, aFlushD, aFlushE, aFlushM, aFwdA, aFwdB, aBusy});
        end
        vectors++;
        if (aCnt !== 16'd0 || bCnt !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_count got %0d/%0d want 0/0", aCnt, bCnt);
        end
        toNext();
        reset = 0; idleIn();
        toNext();
        $display("reset: outputs forced while asserted, counters cleared");
    endtask

    task automatic test_lw_stall();
        MemReadE = 1; RdE = 5; Rs1D = 5;
        @(negedge clk);
        vectors++;
        if ({aStallF, aStallD, aFlushE, aStallE, aFlushD, aFlushM} !== 6'b111000) begin
            miscompares++;
            $display("FAIL lw_stall got %b want 111000", {aStallF, aStallD, aFlushE, aStallE, aFlushD, aFlushM});
        end
        toNext();
        idleIn(); MemReadE = 1; RdE = 0;
        @(negedge clk);
        vectors++;
        if ({aStallF, aStallD, aFlushE} !== 3'b000) begin
            miscompares++;
            $display("FAIL lw_x0 got %b want 000", {aStallF, aStallD, aFlushE});
        end
        vectors++;
        if (aCnt !== 16'd1) begin
            miscompares++;
            $display("FAIL lw_count got %0d want 1", aCnt);
        end
        toNext(); idleIn();
        $display("lw_stall: one stall cycle on x5, none on x0");
    endtask

    task automatic test_forward();
        RdM = 7; RdW = 7; RegWriteM = 1; RegWriteW = 1; Rs1E = 7; Rs2E = 7;
        @(negedge clk);
        vectors++;
        if ({aFwdA, aFwdB, bFwdA, bFwdB} !== 8'b10100000) begin
            miscompares++;
            $display("FAIL fwd_m_priority got %b want 10100000", {aFwdA, aFwdB, bFwdA, bFwdB});
        end
        toNext();
        RegWriteM = 0;
        @(negedge clk);
        vectors++;
        if ({aFwdA, aFwdB} !== 4'b0101) begin
            miscompares++;
            $display("FAIL fwd_w got %b want 0101", {aFwdA, aFwdB});
        end
        toNext();
        Rs1E = 0;
        @(negedge clk);
        vectors++;
        if ({aFwdA, aFwdB} !== 4'b0001) begin
            miscompares++;
            $display("FAIL fwd_x0 got %b want 0001", {aFwdA, aFwdB});
        end
        toNext(); idleIn();
        $display("forward: M priority, W fallback, x0 never forwarded");
    endtask

    task automatic test_mul();
        logic [3:0] exp [3] = '{4'b1110, 4'b1111, 4'b0001};
        MulE = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if ({aStallE, aStallF, aFlushM, aBusy} !== exp[i]) begin
                miscompares++;
                $display("FAIL mul_cycle%0d got %b want %b", i + 1, {aStallE, aStallF, aFlushM, aBusy}, exp[i]);
            end
            toNext();
        end
        idleIn();
        $display("mul: E held two cycles, released on third");
    endtask

    task automatic test_back_to_back();
        bit [5:0] busyPat  = 6'b110110;
        bit [5:0] stallPat = 6'b011011;
        MulE = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            vectors++;
            if (aBusy !== busyPat[i] || aStallE !== stallPat[i]) begin
                miscompares++;
                $display("FAIL b2b_cycle%0d busy/stallE got %b%b want %b%b",
                         i + 1, aBusy, aStallE, busyPat[i], stallPat[i]);
            end
            toNext();
        end
        idleIn();
        vectors++;
        if (aCnt !== 16'd7) begin
            miscompares++;
            $display("FAIL b2b_count got %0d want 7", aCnt);
        end
        $display("back_to_back: two MULs, MUL_LAT cycles each");
    endtask

    task automatic test_branch();
        PCSrcE = 1;
        @(negedge clk);
        vectors++;
        if ({aFlushD, aFlushE, aStallF, aStallD, aFlushM} !== 5'b11000) begin
            miscompares++;
            $display("FAIL branch got %b want 11000", {aFlushD, aFlushE, aStallF, aStallD, aFlushM});
        end
        toNext();
        MemReadE = 1; RdE = 4; Rs2D = 4;
        @(negedge clk);
        vectors++;
        if ({aFlushD, aFlushE, aStallD, aStallF, aStallE} !== 5'b11110) begin
            miscompares++;
            $display("FAIL branch_lw got %b want 11110", {aFlushD, aFlushE, aStallD, aStallF, aStallE});
        end
        toNext();
        MemReadE = 0; MulE = 1;
        @(negedge clk);
        vectors++;
        if ({aFlushD, aFlushE, aStallE, aFlushM} !== 4'b0011) begin
            miscompares++;
            $display("FAIL branch_mul_mask got %b want 0011", {aFlushD, aFlushE, aStallE, aFlushM});
        end
        toNext(); idleIn();
        toNext(); toNext();
        $display("branch: flushes, lw combo, masked under MUL");
    endtask

    task automatic test_fwd_dis_sat();
        RdM = 3; RegWriteM = 1; Rs2D = 3; Rs2E = 3;
        @(negedge clk);
        vectors++;
        if ({bStallD, bStallF, bFlushE, bStallE, bFwdB} !== 6'b111000) begin
            miscompares++;
            $display("FAIL nofwd_raw got %b want 111000", {bStallD, bStallF, bFlushE, bStallE, bFwdB});
        end
        vectors++;
        if ({aStallD, aFwdB} !== 3'b010) begin
            miscompares++;
            $display("FAIL fwd_no_raw got %b want 010", {aStallD, aFwdB});
        end
        for (int i = 0; i < 20; i++) toNext();
        vectors++;
        if (bCnt !== 4'hF) begin
            miscompares++;
            $display("FAIL cnt_saturate got %0d want 15", bCnt);
        end
        StallCntClr = 1;
        toNext();
        vectors++;
        if (bCnt !== 4'd0) begin
            miscompares++;
            $display("FAIL cnt_clear_wins got %0d want 0", bCnt);
        end
        StallCntClr = 0;
        toNext();
        vectors++;
        if (bCnt !== 4'd1) begin
            miscompares++;
            $display("FAIL cnt_after_clear got %0d want 1", bCnt);
        end
        idleIn();
        $display("fwd_dis_sat: RAW stall, saturation, clear priority");
    endtask

    task automatic test_reset_busy();
        MulE = 1;
        toNext();
        idleIn();
        @(negedge clk);
        vectors++;
        if ({aBusy, aStallE} !== 2'b11) begin
            miscompares++;
            $display("FAIL busy_before_reset got %b want 11", {aBusy, aStallE});
        end
        reset = 1;
        #1;
        vectors++;
        if ({aBusy, aStallE, aStallF, aCnt} !== 19'd0) begin
            miscompares++;
            $display("FAIL reset_in_busy got busy=%b stallE=%b stallF=%b cnt=%0d want all 0",
                     aBusy, aStallE, aStallF, aCnt);
        end
        #2 reset = 0;
        toNext();
        @(negedge clk);
        vectors++;
        if ({aBusy, aStallE} !== 2'b00) begin
            miscompares++;
            $display("FAIL after_reset_idle got %b want 00", {aBusy, aStallE});
        end
        toNext();
        $display("reset_busy: op aborted, back to idle");
    endtask

    task automatic test_random();
        int busyLeft [2];
        int cnt [2];
        int mulLat [2] = '{3, 2};
        int cntMax [2] = '{65535, 15};
        logic [10:0] expA, expB;
        reset = 1; idleIn();
        toNext();
        reset = 0;
        busyLeft = '{0, 0};
        cnt = '{0, 0};
        for (int n = 0; n < 400; n++) begin
            Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
            Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
            RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
            RdW  = 5'($urandom_range(0, 3));
            RegWriteE = 1'($urandom_range(0, 1)); RegWriteM = 1'($urandom_range(0, 1));
            RegWriteW = 1'($urandom_range(0, 1)); MemReadE  = 1'($urandom_range(0, 1));
            MulE   = ($urandom_range(0, 3) == 0);
            PCSrcE = MulE ? 1'b0 : ($urandom_range(0, 3) == 0);
            StallCntClr = ($urandom_range(0, 15) == 0);
            @(negedge clk);
            expA = model(1, mulLat[0], busyLeft[0]);
            expB = model(0, mulLat[1], busyLeft[1]);
            vectors++;
            if ({aFwdA, aFwdB, aStallF, aStallD, aStallE, aFlushD, aFlushE, aFlushM, aBusy} !== expA) begin
                miscompares++;
                $display("FAIL rand%0d_ctrlA got %b want %b", n,
                         {aFwdA, aFwdB, aStallF, aStallD, aStallE, aFlushD, aFlushE, aFlushM, aBusy}, expA);
            end
            vectors++;
            if ({bFwdA, bFwdB, bStallF, bStallD, bStallE, bFlushD, bFlushE, bFlushM, bBusy} !== expB) begin
                miscompares++;
                $display("FAIL rand%0d_ctrlB got %b want %b", n,
                         {bFwdA, bFwdB, bStallF, bStallD, bStallE, bFlushD, bFlushE, bFlushM, bBusy}, expB);
            end
            vectors++;
            if (int'(aCnt) != cnt[0] || int'(bCnt) != cnt[1]) begin
                miscompares++;
                $display("FAIL rand%0d_count got %0d/%0d want %0d/%0d", n, aCnt, bCnt, cnt[0], cnt[1]);
            end
            for (int k = 0; k < 2; k++) begin
                logic stallF;
                stallF = (k == 0) ? expA[6] : expB[6];
                if (StallCntClr) cnt[k] = 0;
                else if (stallF && cnt[k] < cntMax[k]) cnt[k]++;
                if (busyLeft[k] > 0) busyLeft[k]--;
                else if (MulE && mulLat[k] > 1) busyLeft[k] = mulLat[k] - 1;
            end
            toNext();
        end
        idleIn();
        $display("random: 400 cycles against rule model");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lw_stall();
        test_forward();
        test_mul();
        test_back_to_back();
        test_branch();
        test_fwd_dis_sat();
        test_reset_busy();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
